// File: rtl/unified_memory_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and
// data load/store. Ties alternate between the ports, and a wait timeout turns a missing ack into an error.
module unified_memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inst_req,
    input  logic [ADDR_WIDTH-1:0]   inst_address,
    output logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    input  logic                    data_req,
    input  logic                    data_write,
    input  logic [ADDR_WIDTH-1:0]   data_address,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic [DATA_WIDTH/8-1:0] data_wmask,
    output logic                    data_ready,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    mem_req,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    access_error,
    output logic                    busy
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, INST_WAIT, DATA_WAIT, DONE} state_t;

    state_t                  state, state_next;
    logic                    last_data, last_data_next;
    logic                    grant_data, grant_data_next;
    logic [15:0]             wait_count, wait_count_next;
    logic                    error_flag, error_next;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_next;
    logic                    mem_req_next, mem_write_next;
    logic [ADDR_WIDTH-1:0]   mem_address_next;
    logic [DATA_WIDTH-1:0]   mem_wdata_next;
    logic [MASK_WIDTH-1:0]   mem_wmask_next;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            last_data   <= 1'b0;
            grant_data  <= 1'b0;
            wait_count  <= '0;
            error_flag  <= 1'b0;
            rdata_q     <= '0;
            mem_req     <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
        end else begin
            state       <= state_next;
            last_data   <= last_data_next;
            grant_data  <= grant_data_next;
            wait_count  <= wait_count_next;
            error_flag  <= error_next;
            rdata_q     <= rdata_next;
            mem_req     <= mem_req_next;
            mem_write   <= mem_write_next;
            mem_address <= mem_address_next;
            mem_wdata   <= mem_wdata_next;
            mem_wmask   <= mem_wmask_next;
        end
    end

    always_comb begin
        state_next       = state;
        last_data_next   = last_data;
        grant_data_next  = grant_data;
        wait_count_next  = wait_count;
        error_next       = error_flag;
        rdata_next       = rdata_q;
        mem_req_next     = mem_req;
        mem_write_next   = mem_write;
        mem_address_next = mem_address;
        mem_wdata_next   = mem_wdata;
        mem_wmask_next   = mem_wmask;
        case (state)
            IDLE: begin
                wait_count_next = '0;
                error_next      = 1'b0;
                // Data wins unless inst also requests and data had the previous grant.
                if (data_req && (!inst_req || !last_data)) begin
                    state_next       = DATA_WAIT;
                    last_data_next   = 1'b1;
                    grant_data_next  = 1'b1;
                    mem_req_next     = 1'b1;
                    mem_write_next   = data_write;
                    mem_address_next = data_address;
                    mem_wdata_next   = data_wdata;
                    mem_wmask_next   = data_write ? data_wmask : '0;
                end else if (inst_req) begin
                    state_next       = INST_WAIT;
                    last_data_next   = 1'b0;
                    grant_data_next  = 1'b0;
                    mem_req_next     = 1'b1;
                    mem_write_next   = 1'b0;
                    mem_address_next = inst_address;
                    mem_wdata_next   = '0;
                    mem_wmask_next   = '0;
                end
            end
            INST_WAIT, DATA_WAIT: begin
                if (mem_ack) begin
                    rdata_next   = (state == DATA_WAIT && mem_write) ? '0 : mem_rdata;
                    mem_req_next = 1'b0;
                    state_next   = DONE;
                end else if (wait_count == WAIT_LIMIT) begin
                    wait_count_next = wait_count + 16'd1;
                    rdata_next      = '0;
                    error_next      = 1'b1;
                    mem_req_next    = 1'b0;
                    state_next      = DONE;
                end else begin
                    wait_count_next = wait_count + 16'd1;
                end
            end
            default: begin
                wait_count_next = '0;
                error_next      = 1'b0;
                state_next      = IDLE;
            end
        endcase
    end

    assign busy         = (state != IDLE);
    assign inst_ready   = (state == DONE) && !grant_data;
    assign data_ready   = (state == DONE) && grant_data;
    assign inst_rdata   = inst_ready ? rdata_q : '0;
    assign data_rdata   = data_ready ? rdata_q : '0;
    assign access_error = (state == DONE) && error_flag;

    // A requester must hold its request until its ready pulse.
    inst_req_held: assert property (@(posedge clock) disable iff (!reset)
        (state == INST_WAIT) |-> inst_req);
    data_req_held: assert property (@(posedge clock) disable iff (!reset)
        (state == DATA_WAIT) |-> data_req);
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Bench for unified_memory_arbiter: directed plan steps then random traffic, checked
// every cycle against a transaction-timeline reference model.
module tb_unified_memory_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MW   = DW / 8;
    localparam int MAXW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_address = '0;
    logic          inst_ready;
    logic [DW-1:0] inst_rdata;
    logic          data_req = 1'b0;
    logic          data_write = 1'b0;
    logic [AW-1:0] data_address = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [MW-1:0] data_wmask = '0;
    logic          data_ready;
    logic [DW-1:0] data_rdata;
    logic          mem_req, mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          access_error, busy;

    always #5 clock = ~clock;

    unified_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset),
        .inst_req(inst_req), .inst_address(inst_address),
        .inst_ready(inst_ready), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_write(data_write), .data_address(data_address),
        .data_wdata(data_wdata), .data_wmask(data_wmask),
        .data_ready(data_ready), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .access_error(access_error), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit checking = 0;

    // Reference: one access at a time as a timeline. Granted in cycle g, mem_req in
    // g+1..g+w, ready in g+w+1, idle again from g+w+2.
    bit            act = 0;
    int            g = 0, w = 0, k = 0;
    bit            win_d = 0, err = 0, last_d = 0, ewr = 0;
    logic [DW-1:0] erd = '0, ackd = '0, ewd = '0;
    logic [AW-1:0] ea = '0;
    logic [MW-1:0] em = '0;
    int            rst_cyc = -1;

    int            inst_rate = 0, data_rate = 0;
    int            kfix = -1;
    bit            ackd_force = 0;
    logic [DW-1:0] ackd_val = '0;
    bit            spurious = 0;
    bit            inst_done = 0, data_done = 0;
    bit            order[$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit in_req, rdy;
        in_req = act && cyc > g && cyc <= g + w;
        rdy    = act && cyc == g + w + 1;
        chk1("busy", busy, act && cyc > g && cyc <= g + w + 1);
        chk1("mem_req", mem_req, in_req);
        if (in_req) begin
            chkw("mem_address", mem_address, ea);
            chk1("mem_write", mem_write, ewr);
            chkw("mem_wmask", 32'(mem_wmask), 32'(em));
            if (ewr) chkw("mem_wdata", mem_wdata, ewd);
        end
        chk1("inst_ready", inst_ready, rdy && !win_d);
        chk1("data_ready", data_ready, rdy && win_d);
        chkw("inst_rdata", inst_rdata, (rdy && !win_d) ? erd : 32'h0);
        chkw("data_rdata", data_rdata, (rdy && win_d) ? erd : 32'h0);
        chk1("access_error", access_error, rdy && err);
        if (cyc == rst_cyc) begin
            chkw("rst_mem_address", mem_address, 32'h0);
            chkw("rst_mem_wdata", mem_wdata, 32'h0);
            chkw("rst_mem_wmask", 32'(mem_wmask), 32'h0);
            chk1("rst_mem_write", mem_write, 1'b0);
        end
        if (inst_ready || data_ready) order.push_back(data_ready);
        inst_done = rdy && !win_d;
        data_done = rdy && win_d;
    endtask

    task automatic drive_requests();
        if (inst_done) inst_req = 1'b0;
        if (data_done) data_req = 1'b0;
        if (!inst_req && $urandom_range(1, 100) <= inst_rate) begin
            inst_req     = 1'b1;
            inst_address = $urandom;
        end
        if (!data_req && $urandom_range(1, 100) <= data_rate) begin
            data_req     = 1'b1;
            data_write   = 1'($urandom_range(0, 1));
            data_address = $urandom;
            data_wdata   = $urandom;
            data_wmask   = MW'($urandom);
        end
    endtask

    task automatic drive_memory();
        bit in_win;
        in_win = act && cyc > g && cyc <= g + w;
        if (act && k > 0 && cyc == g + k) begin
            mem_ack   = 1'b1;
            mem_rdata = ackd;
        end else begin
            mem_ack   = spurious && !in_win && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    endtask

    task automatic try_grant();
        if (inst_req || data_req) begin
            win_d  = data_req && (!inst_req || !last_d);
            last_d = win_d;
            act    = 1;
            g      = cyc;
            k      = (kfix >= 0) ? kfix : int'($urandom_range(0, MAXW + 2));
            ackd   = ackd_force ? ackd_val : $urandom;
            err    = !(k >= 1 && k <= MAXW);
            w      = err ? MAXW : k;
            if (win_d) begin
                ea  = data_address;
                ewr = data_write;
                ewd = data_wdata;
                em  = data_write ? data_wmask : '0;
            end else begin
                ea  = inst_address;
                ewr = 0;
                ewd = '0;
                em  = '0;
            end
            erd = (err || (win_d && ewr)) ? '0 : ackd;
        end
    endtask

    // One clock cycle: inputs set by the caller apply to the current cycle.
    task automatic tick();
        if (checking) check_outputs();
        else begin
            inst_done = 0;
            data_done = 0;
        end
        drive_requests();
        drive_memory();
        if (!reset) begin
            act     = 0;
            last_d  = 0;
            rst_cyc = cyc + 1;
        end else if (!act || cyc >= g + w + 2) begin
            try_grant();
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic post_inst(input logic [AW-1:0] a);
        inst_req     = 1'b1;
        inst_address = a;
    endtask

    task automatic post_data(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [MW-1:0] m);
        data_req     = 1'b1;
        data_write   = wr;
        data_address = a;
        data_wdata   = d;
        data_wmask   = m;
    endtask

    initial begin
        @(negedge clock);
        tick();
        checking = 1;
        ticks(2);
        reset = 1'b1;
        ticks(2);

        // single fetch, ack in second wait cycle
        kfix = 2; ackd_force = 1; ackd_val = 32'h0000_0013;
        post_inst(32'h0040_0000);
        ticks(6);

        // store, ack in fourth wait cycle
        kfix = 4;
        post_data(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b0011);
        ticks(8);

        // contention from reset, immediate acks
        ackd_force = 0; kfix = 1;
        post_inst(32'h0000_1000);
        post_data(1'b0, 32'h2000_0000, 32'h0, 4'h0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        order.delete();
        inst_rate = 100; data_rate = 100;
        ticks(16);
        inst_rate = 0; data_rate = 0;
        ticks(8);
        chk1("contention_grants", order.size() >= 4, 1'b1);
        if (order.size() >= 4) begin
            chk1("grant0_data", order[0], 1'b1);
            chk1("grant1_inst", order[1], 1'b0);
            chk1("grant2_data", order[2], 1'b1);
            chk1("grant3_inst", order[3], 1'b0);
            for (int i = 1; i < order.size(); i++)
                chk1("grant_alternates", order[i] != order[i-1], 1'b1);
        end

        // timeout, then a normal fetch
        kfix = 0;
        post_data(1'b0, 32'h3000_0008, 32'h0, 4'h0);
        ticks(8);
        kfix = 1;
        post_inst(32'h0040_0004);
        ticks(5);

        // reset during the second wait cycle, then re-grant of the held request
        kfix = 0;
        post_data(1'b0, 32'h3000_0010, 32'h0, 4'h0);
        ticks(2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        kfix = 2;
        ticks(8);

        // ack exactly on the last allowed wait cycle
        kfix = 4; ackd_force = 1; ackd_val = 32'h1234_5678;
        post_data(1'b0, 32'h3000_0020, 32'h0, 4'h0);
        ticks(8);

        // random traffic with late and spurious acks
        ackd_force = 0; kfix = -1; spurious = 1;
        inst_rate = 40; data_rate = 40;
        ticks(1500);
        inst_rate = 0; data_rate = 0;
        ticks(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unified_memory_arbiter.md
Name: unified_memory_arbiter

Overview:
- Shares one single-port, variable-latency memory between the core's instruction-fetch port and data load/store port. Used when the core is built against a unified memory instead of split instruction/data memories.
- Sequences each access with a request/ack handshake to memory and returns a one-cycle ready pulse to the winning requester.
- Tie-breaking alternates between requesters. A wait timeout turns a missing memory ack into an error response instead of a hang.

Parameters:
- ADDR_WIDTH, 32, width of all address ports
- DATA_WIDTH, 32, width of all data ports; multiple of 8
- MAX_WAIT, 255, maximum memory-wait cycles before timeout; range 1..65535

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
- inst_req  input  1  fetch request; held with inst_address until inst_ready
- inst_address  input  ADDR_WIDTH  fetch address
- inst_ready  output  1  one-cycle completion pulse to fetch port
- inst_rdata  output  DATA_WIDTH  fetched word; valid while inst_ready=1
- data_req  input  1  load/store request; held with all data_* inputs until data_ready
- data_write  input  1  1=store, 0=load
- data_address  input  ADDR_WIDTH  load/store address
- data_wdata  input  DATA_WIDTH  store data
- data_wmask  input  DATA_WIDTH/8  store byte enables
- data_ready  output  1  one-cycle completion pulse to data port
- data_rdata  output  DATA_WIDTH  load result; valid while data_ready=1
- mem_req  output  1  memory request; held until mem_ack or timeout
- mem_write  output  1  memory write strobe qualifier
- mem_address  output  ADDR_WIDTH  registered memory address
- mem_wdata  output  DATA_WIDTH  registered write data
- mem_wmask  output  DATA_WIDTH/8  registered byte enables; all-zero for reads
- mem_ack  input  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  input  DATA_WIDTH  memory read data
- access_error  output  1  pulses together with a ready pulse when that access timed out
- busy  output  1  1 in every state except IDLE

Behaviour:
- States: IDLE, INST_WAIT, DATA_WAIT, DONE. Reset state is IDLE.
- Reset values: every output is 0; last_grant=INST; wait counter=0.
- IDLE:
  - Requests are sampled only in IDLE. On grant, the mem_* outputs are registered from the winner's inputs and mem_req=1 from the next cycle.
  - Only data_req=1: grant data, go to DATA_WAIT.
  - Only inst_req=1: grant inst, go to INST_WAIT.
  - Both requesting: grant the requester that is not last_grant. The first tie after reset therefore goes to data.
  - Update last_grant on every grant.
- INST_WAIT / DATA_WAIT:
  - mem_req and all mem_* outputs are held stable.
  - The wait counter increments each cycle with mem_ack=0.
  - mem_ack=1: capture mem_rdata into the winner's rdata register (data_rdata=0 for stores), drop mem_req next cycle, go to DONE.
  - Counter reaches MAX_WAIT with mem_ack=0: drop mem_req, rdata=0, set error flag, go to DONE.
- DONE:
  - Exactly one cycle. The winner's ready=1, and access_error=1 if the error flag is set. Then go to IDLE.
  - Wait counter and error flag clear.
  - ready, rdata and access_error are 0 in all other cycles.
- Latency: request seen in IDLE at cycle N gives mem_req=1 at N+1. mem_ack at cycle N+k gives ready at N+k+1. Minimum request-to-ready latency is 2 cycles.
- Back-to-back: a requester that keeps req=1 in the cycle after its ready pulse issues a new request. That request is sampled when the block returns to IDLE, which is that same cycle.
- Starvation-free: with both ports requesting continuously, grants strictly alternate.
- mem_ack while in IDLE or DONE is ignored.
- mem_ack in the same cycle the counter reaches MAX_WAIT counts as success, not timeout.
- Reset mid-access: mem_req=0 after that edge, no ready pulse is issued, state returns to IDLE. A requester still holding req is re-arbitrated after reset is released.
- A req dropped before its ready pulse is a protocol violation. Behaviour is undefined; an assertion flags it.

Test Plan:
- Single fetch: inst_req=1, inst_address=0x00400000; memory acks 1 cycle after mem_req with 0x00000013 -> mem_address=0x00400000, mem_wmask=0; inst_ready pulses once at cycle 3 with inst_rdata=0x00000013; busy=1 for 3 cycles.
- Store: data_req=1, data_write=1, data_address=0x10010004, data_wdata=0xDEADBEEF, data_wmask=4'b0011; ack after 3 cycles -> mem_write=1, mem_wmask=4'b0011 held all 4 wait cycles; data_ready pulses once with data_rdata=0.
- Contention: both ports request continuously from reset; memory acks immediately -> grant order data, inst, data, inst; no two consecutive grants to the same port.
- Timeout with MAX_WAIT=4: load, mem_ack never asserted -> mem_req high exactly 4 cycles; data_ready=1 and access_error=1 in the same cycle; data_rdata=0; next fetch completes normally.
- Reset mid-access: reset=0 during DATA_WAIT cycle 2 -> mem_req=0 and busy=0 after that edge, no data_ready pulse; after reset=1, held data_req is re-granted and completes.
- Boundary ack: MAX_WAIT=4, mem_ack arrives exactly at wait cycle 4 with 0x12345678 -> data_rdata=0x12345678, access_error=0.
